// File: rtl/instr_dcd_pkg.sv
// Shared types and constants for the burst-capable SPI instruction decoder.
package instr_dcd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    XFER    = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int RW_BIT  = 7;
  localparam int INC_BIT = 6;

  function automatic int data_w(input int data_bytes);
    return 8 * data_bytes;
  endfunction

endpackage

// File: rtl/instr_dcd_burst_if.sv
// Byte-side SPI signals and register-file bus seen by the decoder.
interface instr_dcd_burst_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
);
  logic              frame_active;
  logic              byte_sync;
  logic [7:0]        data_in;
  logic [7:0]        data_out;
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_read;
  logic [DATA_W-1:0] data_write;
  logic              busy;

  modport master (
    input  frame_active, byte_sync, data_in, data_read,
    output data_out, read, write, addr, data_write, busy
  );

  modport slave (
    output frame_active, byte_sync, data_in, data_read,
    input  data_out, read, write, addr, data_write, busy
  );
endinterface

// File: rtl/instr_dcd_burst_byte_shifter.sv
// MSB-first word shifter with parallel load; remain down-counts to the last byte of a word.
module instr_dcd_burst_byte_shifter
  import instr_dcd_pkg::*;
#(
  parameter  int DATA_BYTES = 2,
  localparam int DATA_W     = data_w(DATA_BYTES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] load_word,
  input  logic              shift,
  input  logic [7:0]        shift_in,
  output logic [DATA_W-1:0] shifted,
  output logic [7:0]        msb_byte,
  output logic              last
);
  localparam logic [1:0] REMAIN_INIT = 2'(DATA_BYTES - 1);

  logic [DATA_W-1:0] word;
  logic [1:0]        remain;

  assign shifted  = DATA_W'({word, shift_in});
  assign msb_byte = word[DATA_W-1 -: 8];
  assign last     = (remain == 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word   <= '0;
      remain <= REMAIN_INIT;
    end else if (clr) begin
      word   <= '0;
      remain <= REMAIN_INIT;
    end else if (load) begin
      word   <= load_word;
      remain <= REMAIN_INIT;
    end else if (shift) begin
      word   <= shifted;
      remain <= last ? REMAIN_INIT : remain - 2'd1;
    end
  end
endmodule

// File: rtl/instr_dcd_burst.sv
// SPI instruction decoder moving multi-byte register words, with auto-increment bursts.
//   state   | meaning
//   IDLE    | waiting for the instruction byte of a frame
//   RD_WAIT | read strobe issued, waiting RD_LAT cycles for data_read
//   XFER    | shifting data bytes (write assembly or read readout)
//   DONE    | word finished without increment; ignore bytes until frame ends
module instr_dcd_burst
  import instr_dcd_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int DATA_BYTES = 2,
  parameter int RD_LAT     = 1
) (
  input  logic               clk,
  input  logic               rst,
  instr_dcd_burst_if.master  bus
);
  localparam int DATA_W = data_w(DATA_BYTES);

  state_t            state, state_d;
  logic              rw_q, inc_q;
  logic [ADDR_W-1:0] addr_q;
  logic              read_q, write_q;
  logic [DATA_W-1:0] data_write_q;
  logic [1:0]        lat_cnt;

  logic              sh_clr, sh_load, sh_shift, sh_last;
  logic [DATA_W-1:0] sh_shifted;
  logic [7:0]        sh_msb;
  logic              read_d, write_d, lat_load, latch_ins, addr_inc;

  instr_dcd_burst_byte_shifter #(.DATA_BYTES(DATA_BYTES)) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .clr       (sh_clr),
    .load      (sh_load),
    .load_word (bus.data_read),
    .shift     (sh_shift),
    .shift_in  (rw_q ? bus.data_in : 8'h00),
    .shifted   (sh_shifted),
    .msb_byte  (sh_msb),
    .last      (sh_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d   = state;
    sh_clr    = 1'b0;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    read_d    = 1'b0;
    write_d   = 1'b0;
    lat_load  = 1'b0;
    latch_ins = 1'b0;
    addr_inc  = 1'b0;
    // Chip-select release wins over everything, including a coincident byte.
    if (!bus.frame_active) begin
      state_d = IDLE;
      sh_clr  = 1'b1;
    end else begin
      case (state)
        IDLE: if (bus.byte_sync) begin
          latch_ins = 1'b1;
          sh_clr    = 1'b1;
          if (bus.data_in[RW_BIT]) begin
            state_d = XFER;
          end else begin
            read_d   = 1'b1;
            lat_load = 1'b1;
            state_d  = RD_WAIT;
          end
        end
        RD_WAIT: if (lat_cnt == 2'd0) begin
          sh_load = 1'b1;
          state_d = XFER;
        end
        XFER: if (rw_q) begin
          // Address advances only once the write strobe has used it.
          addr_inc = write_q && inc_q;
          if (bus.byte_sync) begin
            sh_shift = 1'b1;
            if (sh_last) begin
              write_d = 1'b1;
              if (!inc_q) state_d = DONE;
            end
          end
        end else if (bus.byte_sync) begin
          sh_shift = 1'b1;
          if (sh_last) begin
            if (inc_q) begin
              addr_inc = 1'b1;
              read_d   = 1'b1;
              lat_load = 1'b1;
              state_d  = RD_WAIT;
            end else begin
              state_d = DONE;
            end
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rw_q         <= 1'b0;
      inc_q        <= 1'b0;
      addr_q       <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      data_write_q <= '0;
      lat_cnt      <= 2'd0;
    end else begin
      read_q  <= read_d;
      write_q <= write_d;
      if (write_d) data_write_q <= sh_shifted;
      if (latch_ins) begin
        rw_q   <= bus.data_in[RW_BIT];
        inc_q  <= bus.data_in[INC_BIT];
        addr_q <= bus.data_in[ADDR_W-1:0];
      end else if (addr_inc) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
      if (lat_load)                                lat_cnt <= 2'(RD_LAT);
      else if (state == RD_WAIT && lat_cnt != 2'd0) lat_cnt <= lat_cnt - 2'd1;
    end
  end

  assign bus.read       = read_q;
  assign bus.write      = write_q;
  assign bus.addr       = addr_q;
  assign bus.data_write = data_write_q;
  assign bus.data_out   = (state == XFER && !rw_q) ? sh_msb : 8'h00;
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_instr_dcd_burst.sv
// Bench for instr_dcd_burst: frame-level reference model, latency-accurate register file, strobe scoreboard.
module tb_instr_dcd_burst;
  localparam int AW = 6;
  localparam int DB = 2;
  localparam int DW = 16;
  localparam int RL = 1;
  localparam int NA = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_dcd_burst_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  instr_dcd_burst #(.ADDR_W(AW), .DATA_BYTES(DB), .RD_LAT(RL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; int addr; int data;} ev_t;
  ev_t exp_wr[$];
  ev_t exp_rd[$];
  ev_t ce;
  int wr_count = 0, rd_count = 0;
  int last_wr_addr = 0, last_wr_data = 0, last_rd_addr = 0;
  logic [DW-1:0] regs [NA];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Register file: data_read holds the addressed word only RD_LAT cycles after the strobe.
  logic [3:0] pv = '0;
  int pa [4] = '{0, 0, 0, 0};
  always @(negedge clk) begin
    pv = {pv[2:0], bus.read};
    for (int i = 3; i > 0; i--) pa[i] = pa[i-1];
    pa[0] = int'(bus.addr);
    bus.data_read = pv[RL] ? regs[pa[RL]] : DW'($urandom);
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.read || bus.write) chk("rw_exclusive", bus.read & bus.write, 0);
      if (bus.write) begin
        total++;
        if (exp_wr.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: addr %0h data %0h, none expected", bus.addr, bus.data_write);
        end else begin
          ce = exp_wr.pop_front();
          chk("wr_cycle", cyc, ce.cyc);
          chk("wr_addr", bus.addr, ce.addr);
          chk("wr_data", bus.data_write, ce.data);
        end
        wr_count++;
        last_wr_addr = int'(bus.addr);
        last_wr_data = int'(bus.data_write);
      end
      if (bus.read) begin
        total++;
        if (exp_rd.size() == 0) begin
          bad++;
          $display("FAIL unexpected_read: addr %0h, none expected", bus.addr);
        end else begin
          ce = exp_rd.pop_front();
          chk("rd_cycle", cyc, ce.cyc);
          chk("rd_addr", bus.addr, ce.addr);
        end
        rd_count++;
        last_rd_addr = int'(bus.addr);
      end
    end
  end

  // data_out a frame must present after j data bytes have been shifted.
  function automatic logic [7:0] exp_dout(input logic [7:0] ins, input int j);
    int a, w, k;
    if (ins[7]) return 8'h00;
    if (!ins[6] && j >= DB) return 8'h00;
    a = int'(ins[AW-1:0]);
    w = j / DB;
    k = j % DB;
    return 8'(regs[(a + w) % NA] >> (8 * (DB - 1 - k)));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b[$], input bit rst_mid);
    logic [7:0] ins;
    int a, w;
    ins = 8'h00;
    a = 0;
    bus.frame_active = 1'b1;
    tick();
    tick();
    for (int i = 0; i < b.size(); i++) begin
      if (i > 0) chk("dout_before_byte", bus.data_out, exp_dout(ins, i - 1));
      bus.data_in   = b[i];
      bus.byte_sync = 1'b1;
      if (i == 0) begin
        ins = b[0];
        a   = int'(ins[AW-1:0]);
        if (!ins[7]) exp_rd.push_back('{cyc + 1, a, 0});
      end else if (ins[7]) begin
        if (i % DB == 0 && (ins[6] || i == DB)) begin
          w = 0;
          for (int k = i - DB + 1; k <= i; k++) w = (w << 8) | int'(b[k]);
          exp_wr.push_back('{cyc + 1, (a + i / DB - 1) % NA, w});
        end
      end else if (ins[6] && i % DB == 0) begin
        exp_rd.push_back('{cyc + 1, (a + i / DB) % NA, 0});
      end
      tick();
      bus.byte_sync = 1'b0;
      bus.data_in   = 8'($urandom);
      repeat (RL + 2 + $urandom_range(0, 3)) tick();
    end
    if (b.size() > 0) begin
      chk("dout_end", bus.data_out, exp_dout(ins, b.size() - 1));
      chk("busy_in_frame", bus.busy, 1);
    end
    if (rst_mid) begin
      #3 rst = 1'b1;
      #1;
      chk("rst_read", bus.read, 0);
      chk("rst_write", bus.write, 0);
      chk("rst_addr", bus.addr, 0);
      chk("rst_data_write", bus.data_write, 0);
      chk("rst_data_out", bus.data_out, 0);
      chk("rst_busy", bus.busy, 0);
      bus.frame_active = 1'b0;
      tick();
      tick();
      rst = 1'b0;
    end
    bus.frame_active = 1'b0;
    tick();
    chk("busy_after_frame", bus.busy, 0);
    chk("dout_after_frame", bus.data_out, 0);
    repeat (3) tick();
    chk("pending_writes", exp_wr.size(), 0);
    chk("pending_reads", exp_rd.size(), 0);
    exp_wr.delete();
    exp_rd.delete();
  endtask

  logic [7:0] fb[$];
  int w0, r0, nb;

  initial begin
    bus.frame_active = 1'b0;
    bus.byte_sync    = 1'b0;
    bus.data_in      = 8'h00;
    for (int i = 0; i < NA; i++) regs[i] = DW'($urandom);
    regs[6'h10] = 16'hA1A2;
    regs[6'h11] = 16'hB1B2;
    regs[6'h12] = 16'h1234;
    tick();
    tick();
    chk("reset_read", bus.read, 0);
    chk("reset_write", bus.write, 0);
    chk("reset_addr", bus.addr, 0);
    chk("reset_data_write", bus.data_write, 0);
    chk("reset_data_out", bus.data_out, 0);
    chk("reset_busy", bus.busy, 0);
    rst = 1'b0;
    tick();

    w0 = wr_count;
    fb = {8'h85, 8'hAB, 8'hCD};
    send_frame(fb, 1'b0);
    chk("pin_single_wr_cnt", wr_count - w0, 1);
    chk("pin_single_wr_addr", last_wr_addr, 'h05);
    chk("pin_single_wr_data", last_wr_data, 'hABCD);

    w0 = wr_count;
    fb = {8'hFE, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_frame(fb, 1'b0);
    chk("pin_burst_wr_cnt", wr_count - w0, 3);
    chk("pin_burst_wr_addr", last_wr_addr, 'h00);
    chk("pin_burst_wr_data", last_wr_data, 'h5566);

    r0 = rd_count;
    fb = {8'h12, 8'h00, 8'h00};
    send_frame(fb, 1'b0);
    chk("pin_single_rd_cnt", rd_count - r0, 1);
    chk("pin_single_rd_addr", last_rd_addr, 'h12);

    r0 = rd_count;
    fb = {8'h50, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(fb, 1'b0);
    chk("pin_burst_rd_cnt", rd_count - r0, 3);
    chk("pin_burst_rd_last_addr", last_rd_addr, 'h12);

    w0 = wr_count;
    fb = {8'h85, 8'hAB};
    send_frame(fb, 1'b0);
    chk("pin_abort_wr_cnt", wr_count - w0, 0);
    fb = {8'h85, 8'h01, 8'h02};
    send_frame(fb, 1'b0);
    chk("pin_after_abort_wr_cnt", wr_count - w0, 1);
    chk("pin_after_abort_wr_data", last_wr_data, 'h0102);

    w0 = wr_count;
    fb = {8'h85, 8'h01, 8'h02, 8'h03};
    send_frame(fb, 1'b0);
    chk("pin_noinc_wr_cnt", wr_count - w0, 1);

    w0 = wr_count;
    fb = {8'hC5, 8'h01, 8'h02, 8'h03};
    send_frame(fb, 1'b1);
    chk("pin_rst_wr_cnt", wr_count - w0, 1);
    chk("pin_rst_wr_data", last_wr_data, 'h0102);

    for (int f = 0; f < 25; f++) begin
      fb.delete();
      nb = $urandom_range(0, 7);
      fb.push_back(8'($urandom));
      for (int i = 0; i < nb; i++) fb.push_back(8'($urandom));
      send_frame(fb, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_dcd_burst.md
Name: instr_dcd_burst

Overview:
Parametrised successor to the single-byte SPI instruction decoder. Decodes an instruction byte from the SPI slave, then moves multi-byte register words MSB-first, with optional address auto-increment bursts framed by chip-select. Read data is fetched before the data bytes are shifted, so the SPI slave returns the current register contents in the same frame. Sits between the SPI slave byte interface and the register file.

Parameters:
ADDR_W, 6, register address width (1..6); taken from instruction bits [ADDR_W-1:0].
DATA_BYTES, 2, bytes per register word (1..4); DATA_W = 8*DATA_BYTES.
RD_LAT, 1, cycles from read pulse to valid data_read (0..3).

Ports:
clk  in  1  peripheral clock
rst  in  1  reset; asynchronous, active-high
frame_active  in  1  synchronised chip-select active; low ends the frame
byte_sync  in  1  one-cycle pulse: data_in holds a complete received byte
data_in  in  8  received byte
data_out  out  8  byte for the SPI slave to shift out next
read  out  1  one-cycle register read strobe
write  out  1  one-cycle register write strobe
addr  out  ADDR_W  register address
data_read  in  DATA_W  register read data, valid RD_LAT cycles after read
data_write  out  DATA_W  register write data
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: state IDLE; read, write, busy = 0; addr, data_write, data_out = 0; byte counter and buffers cleared.
- Instruction byte: bit7 = 1 write / 0 read; bit6 = auto-increment; bits[ADDR_W-1:0] = address; unused bits ignored.
- States: IDLE, RD_WAIT, XFER, DONE.
- IDLE + byte_sync: latch rw, inc, addr. Write -> XFER. Read -> read pulse on the next cycle -> RD_WAIT.
- RD_WAIT: after RD_LAT cycles, load data_read into the shift buffer; data_out = MSB byte; -> XFER.
- XFER write: each byte_sync shifts data_in into the assembly register MSB-first. On the DATA_BYTES-th byte, write pulses on the next cycle with data_write = assembled word at current addr; the counter clears. If inc, addr increments mod 2^ADDR_W after the pulse and the state stays XFER; otherwise -> DONE. data_out = 8'h00 throughout a write.
- XFER read: each byte_sync advances data_out to the next byte. After the last byte: if inc, addr+1 (wraps), a new read pulse, -> RD_WAIT; otherwise data_out = 8'h00 and -> DONE.
- DONE: further byte_sync ignored (no strobes); data_out = 8'h00.
- frame_active low: from any state, -> IDLE on the next clock. A partial write word is discarded with no strobe. Counters clear; data_out = 8'h00. This has priority over a coincident byte_sync.
- At most one of read or write is high in any cycle; each is exactly one cycle wide.
- byte_sync spacing is guaranteed >= RD_LAT+3 clk cycles (8 SCK per byte), so a burst refetch completes before the next byte is needed. No overrun handling is required.
- Asynchronous rst mid-burst: all outputs return to reset values immediately; no strobe is issued.

Decomposition:
- Shared package instr_dcd_pkg: state enum, instruction bit positions (RW_BIT=7, INC_BIT=6), helper constant for DATA_W.
- One natural sub-module: byte_shifter. A DATA_BYTES-wide MSB-first shift/assembly register with parallel load, byte counter and last-byte flag, shared by the read and write paths.

Test Plan:
- Single write (ADDR_W=6, DATA_BYTES=2): frame, bytes 0x85,0xAB,0xCD -> one write pulse, addr=0x05, data_write=0xABCD, one cycle after the third byte_sync; data_out stays 0x00.
- Burst write with wrap: 0xFE,0x11,0x22,0x33,0x44,0x55,0x66 -> writes 0x1122@0x3E, 0x3344@0x3F, 0x5566@0x00.
- Single read, RD_LAT=1: 0x12, data_read=0x1234 -> read pulse addr=0x12 one cycle after byte_sync; data_out=0x12 before the first data byte, 0x34 after it, 0x00 after the second.
- Burst read: 0x50 (inc, addr 0x10), regs 0x10=0xA1A2, 0x11=0xB1B2 -> data_out sequence A1,A2,B1,B2; read pulses at 0x10 then 0x11.
- Abort: 0x85,0xAB then frame_active low -> no write pulse; busy=0 next cycle. A new frame 0x85,0x01,0x02 writes 0x0102 correctly.
- Non-inc extra bytes plus reset: 0x85,0x01,0x02,0x03 -> single write only. Assert rst mid-burst -> all outputs zero, state IDLE, no strobe.
